camera_frame_parser: RTL and testbench

Per-camera input stage between a camera's clock-crossing FIFO (first-word-fall-through, `~empty` as valid, `rd_en` as ack) and the multi-camera patch synchronizer. It consumes `{patch_num, fp}` words, recognises the SOF (`patch_num` all-ones) and EOF (`patch_num` all-ones minus 1) markers, and forwards only in-frame data patches through a one-entry output register with a valid/ready handshake. It also counts patches and frames, and latches a sticky error on protocol violations. One instance is built per camera.

---
 rtl/camera_frame_parser_if.sv | 37 +++
 rtl/camera_frame_parser.sv | 195 +++++++++++++++++++
 tb/tb_camera_frame_parser.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/camera_frame_parser_if.sv
// Stream bundle between a camera FIFO, the frame parser and the patch
// synchronizer. The parser drives the FIFO read side and the output
// register side; the environment drives the opposite directions.
interface camera_frame_parser_if #(
    parameter int PN_W    = 20,
    parameter int FP_SIZE = 20
) ();
    logic                    in_val;
    logic [PN_W+FP_SIZE-1:0] in_data;
    logic                    in_ack;
    logic                    out_val;
    logic                    out_rdy;
    logic [PN_W-1:0]         out_patch_num;
    logic [FP_SIZE-1:0]      out_fp;

    // Parser side: consumes FIFO words, produces held patches.
    modport master (
        input  in_val,
        input  in_data,
        output in_ack,
        output out_val,
        input  out_rdy,
        output out_patch_num,
        output out_fp
    );

    // Environment side: FIFO plus downstream synchronizer.
    modport slave (
        output in_val,
        output in_data,
        input  in_ack,
        input  out_val,
        output out_rdy,
        input  out_patch_num,
        input  out_fp
    );
endinterface

// File: rtl/camera_frame_parser.sv
// Per-camera frame parser. Reads {patch_num, fp} words from a
// first-word-fall-through FIFO, tracks SOF/EOF framing and forwards in-frame
// data patches through a one-entry valid/ready output register. Keeps patch,
// frame and drop counters and a sticky protocol error code.
module camera_frame_parser #(
    parameter int N_PATCH = 600000,
    parameter int FP_SIZE = 20,
    parameter int PN_W    = 20
) (
    input  logic                  CLK,
    input  logic                  RESET,
    camera_frame_parser_if.master bus,
    output logic                  sof,
    output logic                  eof,
    output logic [PN_W-1:0]       frame_patch_count,
    output logic [15:0]           frame_num,
    output logic [15:0]           drop_count,
    output logic [1:0]            err
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        INTRA    = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [PN_W-1:0] SOF_PN     = {PN_W{1'b1}};
    localparam logic [PN_W-1:0] EOF_PN     = {{(PN_W-1){1'b1}}, 1'b0};
    localparam logic [PN_W-1:0] N_PATCH_PN = PN_W'(N_PATCH);
    localparam logic [PN_W-1:0] PN_ONE     = PN_W'(1);

    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_SOF     = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    state_t               state_q, state_d;
    logic                 out_val_q, out_val_d;
    logic [PN_W-1:0]      out_pn_q, out_pn_d;
    logic [FP_SIZE-1:0]   out_fp_q, out_fp_d;
    logic                 sof_q, sof_d;
    logic                 eof_q, eof_d;
    logic [PN_W-1:0]      patch_count_q, patch_count_d;
    logic [PN_W-1:0]      frame_patch_count_q, frame_patch_count_d;
    logic [15:0]          frame_num_q, frame_num_d;
    logic [15:0]          drop_count_q, drop_count_d;
    logic [1:0]           err_q, err_d;

    logic [PN_W-1:0]      in_pn_s;
    logic [FP_SIZE-1:0]   in_fp_s;
    logic                 is_sof_s;
    logic                 is_eof_s;
    logic                 is_data_s;
    logic                 out_free_s;
    logic                 in_ack_s;
    logic                 load_s;

    assign in_pn_s    = bus.in_data[PN_W+FP_SIZE-1:FP_SIZE];
    assign in_fp_s    = bus.in_data[FP_SIZE-1:0];
    assign is_sof_s   = (in_pn_s == SOF_PN);
    assign is_eof_s   = (in_pn_s == EOF_PN);
    assign is_data_s  = (in_pn_s < N_PATCH_PN);
    // The output slot is usable if empty or being drained on this edge.
    assign out_free_s = !out_val_q || bus.out_rdy;

    // Word classification, framing FSM next state, counters and output slot.
    always_comb begin
        state_d             = state_q;
        out_val_d           = out_val_q;
        out_pn_d            = out_pn_q;
        out_fp_d            = out_fp_q;
        sof_d               = 1'b0;
        eof_d               = 1'b0;
        patch_count_d       = patch_count_q;
        frame_patch_count_d = frame_patch_count_q;
        frame_num_d         = frame_num_q;
        drop_count_d        = drop_count_q;
        err_d               = err_q;
        in_ack_s            = 1'b0;
        load_s              = 1'b0;

        case (state_q)
            WAIT_SOF: begin
                if (bus.in_val) begin
                    in_ack_s = 1'b1;
                    if (is_sof_s) begin
                        sof_d         = 1'b1;
                        patch_count_d = '0;
                        state_d       = INTRA;
                    end else if (drop_count_q != 16'hFFFF) begin
                        drop_count_d = drop_count_q + 16'd1;
                    end else begin
                        drop_count_d = drop_count_q;
                    end
                end else begin
                    in_ack_s = 1'b0;
                end
            end
            INTRA: begin
                if (bus.in_val) begin
                    if (is_sof_s) begin
                        // A new SOF before EOF is fatal; the word stays in the FIFO.
                        state_d = ERROR;
                        err_d   = ERR_SOF;
                    end else if (is_eof_s) begin
                        // Hold EOF until the last forwarded patch has left.
                        if (out_free_s) begin
                            in_ack_s            = 1'b1;
                            eof_d               = 1'b1;
                            frame_patch_count_d = patch_count_q;
                            frame_num_d         = frame_num_q + 16'd1;
                            state_d             = WAIT_SOF;
                        end else begin
                            in_ack_s = 1'b0;
                        end
                    end else if (is_data_s) begin
                        if (patch_count_q == N_PATCH_PN) begin
                            state_d = ERROR;
                            err_d   = ERR_OVERRUN;
                        end else if (out_free_s) begin
                            in_ack_s      = 1'b1;
                            load_s        = 1'b1;
                            patch_count_d = patch_count_q + PN_ONE;
                        end else begin
                            in_ack_s = 1'b0;
                        end
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_RANGE;
                    end
                end else begin
                    in_ack_s = 1'b0;
                end
            end
            ERROR: begin
                // Only reset leaves this state; the FIFO is never read again.
                in_ack_s = 1'b0;
            end
            default: begin
                state_d = ERROR;
            end
        endcase

        if (load_s) begin
            out_val_d = 1'b1;
            out_pn_d  = in_pn_s;
            out_fp_d  = in_fp_s;
        end else if (bus.out_rdy) begin
            out_val_d = 1'b0;
        end else begin
            out_val_d = out_val_q;
        end
    end

    // State and output registers, cleared asynchronously by RESET.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q             <= WAIT_SOF;
            out_val_q           <= 1'b0;
            out_pn_q            <= '0;
            out_fp_q            <= '0;
            sof_q               <= 1'b0;
            eof_q               <= 1'b0;
            patch_count_q       <= '0;
            frame_patch_count_q <= '0;
            frame_num_q         <= 16'd0;
            drop_count_q        <= 16'd0;
            err_q               <= 2'd0;
        end else begin
            state_q             <= state_d;
            out_val_q           <= out_val_d;
            out_pn_q            <= out_pn_d;
            out_fp_q            <= out_fp_d;
            sof_q               <= sof_d;
            eof_q               <= eof_d;
            patch_count_q       <= patch_count_d;
            frame_patch_count_q <= frame_patch_count_d;
            frame_num_q         <= frame_num_d;
            drop_count_q        <= drop_count_d;
            err_q               <= err_d;
        end
    end

    // FIFO read enable is combinational but must stay low while in reset.
    assign bus.in_ack        = in_ack_s & RESET;
    assign bus.out_val       = out_val_q;
    assign bus.out_patch_num = out_pn_q;
    assign bus.out_fp        = out_fp_q;
    assign sof               = sof_q;
    assign eof               = eof_q;
    assign frame_patch_count = frame_patch_count_q;
    assign frame_num         = frame_num_q;
    assign drop_count        = drop_count_q;
    assign err               = err_q;

endmodule

// File: tb/tb_camera_frame_parser.sv
// Directed bench for camera_frame_parser: a default-size instance for framing,
// back-pressure, error and reset scenarios, and a 4-patch instance for overrun.
module tb_camera_frame_parser;

    localparam int PN_W    = 20;
    localparam int FP_SIZE = 20;
    localparam logic [19:0] SOF_PN = 20'hFFFFF;
    localparam logic [19:0] EOF_PN = 20'hFFFFE;
    localparam logic [19:0] FP_KEY = 20'h5A5A5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    camera_frame_parser_if #(.PN_W(PN_W), .FP_SIZE(FP_SIZE)) b0 ();
    camera_frame_parser_if #(.PN_W(PN_W), .FP_SIZE(FP_SIZE)) b1 ();

    logic            sof0, eof0, sof1, eof1;
    logic [PN_W-1:0] fpc0, fpc1;
    logic [15:0]     fn0, fn1, dc0, dc1;
    logic [1:0]      err0, err1;

    camera_frame_parser #(.N_PATCH(600000), .FP_SIZE(FP_SIZE), .PN_W(PN_W)) u0 (
        .CLK(clk), .RESET(rst_n), .bus(b0), .sof(sof0), .eof(eof0),
        .frame_patch_count(fpc0), .frame_num(fn0), .drop_count(dc0), .err(err0)
    );

    camera_frame_parser #(.N_PATCH(4), .FP_SIZE(FP_SIZE), .PN_W(PN_W)) u1 (
        .CLK(clk), .RESET(rst_n), .bus(b1), .sof(sof1), .eof(eof1),
        .frame_patch_count(fpc1), .frame_num(fn1), .drop_count(dc1), .err(err1)
    );

    function automatic logic [39:0] word(input logic [19:0] pn);
        return {pn, pn ^ FP_KEY};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [19:0] pn, input logic rdy);
        b0.in_val  = v;
        b0.in_data = word(pn);
        b0.out_rdy = rdy;
        #1;
    endtask

    task automatic drv1(input logic v, input logic [19:0] pn, input logic rdy);
        b1.in_val  = v;
        b1.in_data = word(pn);
        b1.out_rdy = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state, with a word already waiting in the FIFO.
        drv1(1'b0, 20'd0, 1'b1);
        drv0(1'b1, SOF_PN, 1'b1);
        chk("rst_ack",     b0.in_ack, 1'b0);
        chk("rst_val",     b0.out_val, 1'b0);
        chk("rst_pn",      b0.out_patch_num, 20'd0);
        chk("rst_fp",      b0.out_fp, 20'd0);
        chk("rst_sof",     sof0, 1'b0);
        chk("rst_eof",     eof0, 1'b0);
        chk("rst_fpc",     fpc0, 20'd0);
        chk("rst_fn",      fn0, 16'd0);
        chk("rst_dc",      dc0, 16'd0);
        chk("rst_err",     err0, 2'd0);
        cyc();
        chk("rst_hold_ack", b0.in_ack, 1'b0);
        rst_n = 1'b1;
        #1;

        // Basic frame: SOF, 5, 9, 3, EOF with out_rdy high.
        chk("t1_sof_ack", b0.in_ack, 1'b1);
        cyc();
        chk("t1_sof_pulse", sof0, 1'b1);
        chk("t1_val0", b0.out_val, 1'b0);
        drv0(1'b1, 20'd5, 1'b1);
        chk("t1_d5_ack", b0.in_ack, 1'b1);
        cyc();
        chk("t1_sof_end", sof0, 1'b0);
        chk("t1_val5", b0.out_val, 1'b1);
        chk("t1_pn5", b0.out_patch_num, 20'd5);
        drv0(1'b1, 20'd9, 1'b1);
        cyc();
        chk("t1_pn9", b0.out_patch_num, 20'd9);
        drv0(1'b1, 20'd3, 1'b1);
        cyc();
        chk("t1_pn3", b0.out_patch_num, 20'd3);
        chk("t1_fp3", b0.out_fp, 20'd3 ^ FP_KEY);
        drv0(1'b1, EOF_PN, 1'b1);
        chk("t1_eof_ack", b0.in_ack, 1'b1);
        cyc();
        chk("t1_eof_pulse", eof0, 1'b1);
        chk("t1_val_drained", b0.out_val, 1'b0);
        chk("t1_fpc", fpc0, 20'd3);
        chk("t1_fn", fn0, 16'd1);
        chk("t1_err", err0, 2'd0);
        drv0(1'b0, 20'd0, 1'b1);
        chk("t1_empty_ack", b0.in_ack, 1'b0);
        cyc();
        chk("t1_eof_end", eof0, 1'b0);

        // Words before SOF are dropped.
        do_reset();
        drv0(1'b1, 20'd7, 1'b1);
        chk("t2_drop_ack", b0.in_ack, 1'b1);
        cyc();
        drv0(1'b1, EOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd2, 1'b1);
        cyc();
        chk("t2_dc", dc0, 16'd3);
        chk("t2_no_val", b0.out_val, 1'b0);
        chk("t2_no_err", err0, 2'd0);
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd4, 1'b1);
        cyc();
        chk("t2_val4", b0.out_val, 1'b1);
        chk("t2_pn4", b0.out_patch_num, 20'd4);
        drv0(1'b1, EOF_PN, 1'b1);
        cyc();
        chk("t2_fn", fn0, 16'd1);
        chk("t2_fpc", fpc0, 20'd1);
        chk("t2_dc_keep", dc0, 16'd3);

        // Back-pressure: out_rdy 1,0,0,1 across a 4-patch frame.
        do_reset();
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd10, 1'b1);
        cyc();
        chk("t3_pn10", b0.out_patch_num, 20'd10);
        drv0(1'b1, 20'd11, 1'b0);
        chk("t3_stall_ack", b0.in_ack, 1'b0);
        cyc();
        chk("t3_hold_val_a", b0.out_val, 1'b1);
        chk("t3_hold_pn_a", b0.out_patch_num, 20'd10);
        drv0(1'b1, 20'd11, 1'b0);
        cyc();
        chk("t3_hold_pn_b", b0.out_patch_num, 20'd10);
        chk("t3_hold_fp_b", b0.out_fp, 20'd10 ^ FP_KEY);
        drv0(1'b1, 20'd11, 1'b1);
        chk("t3_drain_ack", b0.in_ack, 1'b1);
        cyc();
        chk("t3_pn11", b0.out_patch_num, 20'd11);
        drv0(1'b1, 20'd12, 1'b1);
        cyc();
        chk("t3_pn12", b0.out_patch_num, 20'd12);
        drv0(1'b1, 20'd13, 1'b1);
        cyc();
        chk("t3_pn13", b0.out_patch_num, 20'd13);
        drv0(1'b1, EOF_PN, 1'b0);
        chk("t3_eof_wait_ack", b0.in_ack, 1'b0);
        cyc();
        chk("t3_eof_wait", eof0, 1'b0);
        chk("t3_val13", b0.out_val, 1'b1);
        chk("t3_pn13_hold", b0.out_patch_num, 20'd13);
        drv0(1'b1, EOF_PN, 1'b1);
        chk("t3_eof_ack", b0.in_ack, 1'b1);
        cyc();
        chk("t3_eof_pulse", eof0, 1'b1);
        chk("t3_val_off", b0.out_val, 1'b0);
        chk("t3_fpc", fpc0, 20'd4);

        // Out-of-range patch number.
        do_reset();
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd1, 1'b1);
        cyc();
        chk("t4_pn1", b0.out_patch_num, 20'd1);
        chk("t4_val1", b0.out_val, 1'b1);
        drv0(1'b1, 20'd600000, 1'b1);
        chk("t4_bad_ack", b0.in_ack, 1'b0);
        cyc();
        chk("t4_err", err0, 2'd1);
        chk("t4_drained", b0.out_val, 1'b0);
        drv0(1'b1, SOF_PN, 1'b1);
        chk("t4_locked_ack_a", b0.in_ack, 1'b0);
        cyc();
        chk("t4_locked_ack_b", b0.in_ack, 1'b0);
        chk("t4_no_sof", sof0, 1'b0);
        chk("t4_err_sticky", err0, 2'd1);

        // SOF inside a frame.
        do_reset();
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd1, 1'b1);
        cyc();
        drv0(1'b1, SOF_PN, 1'b1);
        chk("t5_sof_ack", b0.in_ack, 1'b0);
        cyc();
        chk("t5_err", err0, 2'd2);
        drv0(1'b0, 20'd0, 1'b1);

        // Overrun on the 4-patch instance.
        do_reset();
        drv1(1'b1, SOF_PN, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, 20'(i), 1'b1);
            chk("t5_ov_ack", b1.in_ack, 1'b1);
            cyc();
            chk("t5_ov_pn", b1.out_patch_num, 20'(i));
        end
        chk("t5_ov_err0", err1, 2'd0);
        drv1(1'b1, 20'd1, 1'b1);
        chk("t5_ov_nack", b1.in_ack, 1'b0);
        cyc();
        chk("t5_ov_err", err1, 2'd3);
        chk("t5_ov_val", b1.out_val, 1'b0);
        chk("t5_ov_pn_keep", b1.out_patch_num, 20'd3);
        drv1(1'b0, 20'd0, 1'b1);

        // Reset in the middle of a frame.
        do_reset();
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd2, 1'b1);
        cyc();
        drv0(1'b1, EOF_PN, 1'b1);
        cyc();
        chk("t6_fn_pre", fn0, 16'd1);
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        drv0(1'b1, 20'd3, 1'b1);
        cyc();
        chk("t6_val_pre", b0.out_val, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_val", b0.out_val, 1'b0);
        chk("t6_async_fn", fn0, 16'd0);
        chk("t6_async_fpc", fpc0, 20'd0);
        chk("t6_async_ack", b0.in_ack, 1'b0);
        rst_n = 1'b1;
        drv0(1'b1, 20'd8, 1'b1);
        cyc();
        chk("t6_drop_after_rst", dc0, 16'd1);
        chk("t6_no_fwd", b0.out_val, 1'b0);
        drv0(1'b1, SOF_PN, 1'b1);
        cyc();
        chk("t6_sof", sof0, 1'b1);
        drv0(1'b1, 20'd8, 1'b1);
        cyc();
        chk("t6_pn8", b0.out_patch_num, 20'd8);
        drv0(1'b1, EOF_PN, 1'b1);
        cyc();
        chk("t6_fn", fn0, 16'd1);
        chk("t6_fpc", fpc0, 20'd1);
        chk("t6_err", err0, 2'd0);
        drv0(1'b0, 20'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
